// File: rtl/codec_sample_bridge.sv
// Bridges codec ADC frames to a downstream filter as a mono sample stream. When the codec
// stops producing frames, an internal divider takes over the sample timing.
module codec_sample_bridge #(
  parameter int unsigned W       = 24,
  parameter int unsigned DIV     = 5000,
  parameter int unsigned TIMEOUT = 8192
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         ready,
  input  logic [W-1:0] l_bus_out,
  input  logic [W-1:0] r_bus_out,
  input  logic [1:0]   mode,
  input  logic         filter_busy,
  input  logic         clr_ovr,
  output logic [W-1:0] data_out,
  output logic         sample_trig,
  output logic         overrun,
  output logic         fallback
);

  localparam int unsigned IdleW = ($clog2(TIMEOUT + 1) > 16) ? $clog2(TIMEOUT + 1) : 16;
  localparam int unsigned DivW  = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StCapture,
    StIssue
  } state_e;

  state_e           state_q;
  logic             ready_q;
  logic [W-1:0]     l_lat_q;
  logic [W-1:0]     r_lat_q;
  logic [W-1:0]     data_q;
  logic             sample_trig_q;
  logic             overrun_q;
  logic             fallback_q;
  logic [IdleW-1:0] idle_cnt_q;
  logic [DivW-1:0]  div_cnt_q;

  logic             rise;
  logic             fb_tick;
  logic             ovr_set;
  logic [W:0]       sum;
  logic [W-1:0]     mix;

  assign rise    = ready && !ready_q;
  // A ready edge always wins over the divider: it ends fallback in the same cycle.
  assign fb_tick = fallback_q && !rise && (div_cnt_q == DivW'(DIV - 1));
  assign ovr_set = (rise && ((state_q != StIdle) || filter_busy)) || (fb_tick && filter_busy);

  // Sign-extended sum then drop the LSB: arithmetic shift, rounds toward minus infinity.
  assign sum = {l_lat_q[W-1], l_lat_q} + {r_lat_q[W-1], r_lat_q};

  always_comb begin
    mix = '0;
    unique case (mode)
      2'b00: mix = l_lat_q;
      2'b01: mix = r_lat_q;
      2'b10: mix = sum[W:1];
      2'b11: mix = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      ready_q       <= 1'b0;
      l_lat_q       <= '0;
      r_lat_q       <= '0;
      data_q        <= '0;
      sample_trig_q <= 1'b0;
      overrun_q     <= 1'b0;
      fallback_q    <= 1'b0;
      idle_cnt_q    <= '0;
      div_cnt_q     <= '0;
    end else begin
      ready_q       <= ready;
      sample_trig_q <= 1'b0;

      case (state_q)
        StIdle: begin
          if (rise && !filter_busy) begin
            l_lat_q <= l_bus_out;
            r_lat_q <= r_bus_out;
            state_q <= StCapture;
          end else if (fb_tick && !filter_busy) begin
            sample_trig_q <= 1'b1;
          end
        end
        StCapture: begin
          data_q        <= mix;
          sample_trig_q <= 1'b1;
          state_q       <= StIssue;
        end
        StIssue: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase

      if (ovr_set) begin
        overrun_q <= 1'b1;
      end else if (clr_ovr) begin
        overrun_q <= 1'b0;
      end

      if (rise) begin
        idle_cnt_q <= '0;
      end else if (idle_cnt_q != IdleW'(TIMEOUT)) begin
        idle_cnt_q <= idle_cnt_q + 1'b1;
      end

      if (rise) begin
        fallback_q <= 1'b0;
      end else if (idle_cnt_q == IdleW'(TIMEOUT)) begin
        fallback_q <= 1'b1;
      end

      if (!fallback_q || rise || fb_tick) begin
        div_cnt_q <= '0;
      end else begin
        div_cnt_q <= div_cnt_q + 1'b1;
      end
    end
  end

  assign data_out    = data_q;
  assign sample_trig = sample_trig_q;
  assign overrun     = overrun_q;
  assign fallback    = fallback_q;

endmodule

// File: tb/tb_codec_sample_bridge.sv
// Scoreboard bench for codec_sample_bridge: stimulus pushes expected strobes (data, cycle),
// a negedge monitor pops and compares on every sample_trig.
module tb_codec_sample_bridge;
  localparam int unsigned W = 24;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ready = 1'b0;
  logic [W-1:0] l_in = '0;
  logic [W-1:0] r_in = '0;
  logic [1:0]   mode = 2'b00;
  logic         filter_busy = 1'b0;
  logic         clr_ovr = 1'b0;
  logic [W-1:0] data_out;
  logic         sample_trig;
  logic         overrun;
  logic         fallback;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [W-1:0] exp_d[$];
  int           exp_c[$];
  logic         prev_trig = 1'b0;
  logic [W-1:0] ed;
  int           ec;

  localparam logic [W-1:0] VL[8] = '{24'h123456, 24'h123456, 24'h7FFFFF, 24'hFFFFFF,
                                     24'h800000, 24'h800000, 24'h0ABCDE, 24'h000003};
  localparam logic [W-1:0] VR[8] = '{24'h654321, 24'h654321, 24'h000001, 24'hFFFFFE,
                                     24'h800000, 24'h7FFFFF, 24'h111111, 24'h000000};
  localparam logic [1:0]   VM[8] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b10};
  localparam logic [W-1:0] VE[8] = '{24'h123456, 24'h654321, 24'h400000, 24'hFFFFFE,
                                     24'h800000, 24'hFFFFFF, 24'h000000, 24'h000001};

  codec_sample_bridge #(
    .W      (W),
    .DIV    (10),
    .TIMEOUT(50)
  ) dut (
    .clk        (clk),
    .reset_n    (rst_n),
    .ready      (ready),
    .l_bus_out  (l_in),
    .r_bus_out  (r_in),
    .mode       (mode),
    .filter_busy(filter_busy),
    .clr_ovr    (clr_ovr),
    .data_out   (data_out),
    .sample_trig(sample_trig),
    .overrun    (overrun),
    .fallback   (fallback)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_trig <= 1'b0;
    end else begin
      if (sample_trig) begin
        check("trig_not_consecutive", 32'(prev_trig), 32'd0);
        if (exp_d.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_trig: got strobe data %h at cycle %0d want none",
                   data_out, cyc);
        end else begin
          ed = exp_d.pop_front();
          ec = exp_c.pop_front();
          check("trig_data", 32'(data_out), 32'(ed));
          check("trig_cycle", 32'(cyc), 32'(ec));
        end
      end
      prev_trig <= sample_trig;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) step(1);
  endtask

  task automatic push(input logic [W-1:0] d, input int c);
    exp_d.push_back(d);
    exp_c.push_back(c);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    ready = 1'b0;
    filter_busy = 1'b0;
    clr_ovr = 1'b0;
    mode = 2'b00;
    #1;
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_trig", 32'(sample_trig), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_fallback", 32'(fallback), 32'd0);
    step(2);
    rst_n = 1'b1;
  endtask

  // Launch a ready edge now; the strobe is due two edges later.
  task automatic do_sample(input logic [W-1:0] l, input logic [W-1:0] r, input logic [1:0] m,
                           input logic [W-1:0] e);
    l_in = l;
    r_in = r;
    mode = m;
    ready = 1'b1;
    push(e, cyc + 2);
    step(1);
    ready = 1'b0;
    step(3);
  endtask

  initial begin
    int e;
    apply_reset();

    for (int i = 0; i < 8; i++) do_sample(VL[i], VR[i], VM[i], VE[i]);

    // Mode changes only in the capture cycle count; latched L/R are immune to bus changes.
    l_in = 24'hAAAAAA;
    r_in = 24'h555555;
    mode = 2'b00;
    ready = 1'b1;
    push(24'h555555, cyc + 2);
    step(1);
    ready = 1'b0;
    mode = 2'b01;
    l_in = '0;
    r_in = '0;
    step(1);
    mode = 2'b11;
    step(4);
    check("data_held", 32'(data_out), 32'h555555);

    // Reset asserted during capture aborts the sample.
    l_in = 24'h111111;
    mode = 2'b00;
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_data", 32'(data_out), 32'd0);
    check("abort_trig", 32'(sample_trig), 32'd0);
    step(2);
    rst_n = 1'b1;
    step(6);

    // ready already high at deassertion counts as an edge.
    rst_n = 1'b0;
    l_in = 24'h0F0F0F;
    mode = 2'b00;
    ready = 1'b1;
    step(2);
    rst_n = 1'b1;
    push(24'h0F0F0F, cyc + 2);
    step(1);
    ready = 1'b0;
    step(4);

    // Overrun: busy drop, sticky hold, clear, then set+clear together.
    apply_reset();
    filter_busy = 1'b1;
    ready = 1'b1;
    step(1);
    check("ovr_busy_set", 32'(overrun), 32'd1);
    filter_busy = 1'b0;
    ready = 1'b0;
    step(3);
    check("ovr_hold", 32'(overrun), 32'd1);
    clr_ovr = 1'b1;
    step(1);
    clr_ovr = 1'b0;
    check("ovr_clear", 32'(overrun), 32'd0);
    filter_busy = 1'b1;
    ready = 1'b1;
    clr_ovr = 1'b1;
    step(1);
    clr_ovr = 1'b0;
    filter_busy = 1'b0;
    ready = 1'b0;
    check("ovr_set_wins", 32'(overrun), 32'd1);
    step(3);

    // Back-to-back: second edge lands in ISSUE and is dropped.
    apply_reset();
    l_in = 24'h00BEEF;
    mode = 2'b00;
    ready = 1'b1;
    push(24'h00BEEF, cyc + 2);
    step(1);
    ready = 1'b0;
    step(1);
    l_in = 24'h777777;
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    check("b2b_overrun", 32'(overrun), 32'd1);
    step(4);

    // Fallback: timeout 50, divider 10, held data, busy-suppressed tick, then ready recovers.
    apply_reset();
    l_in = 24'h2468AC;
    mode = 2'b00;
    ready = 1'b1;
    push(24'h2468AC, cyc + 2);
    e = cyc + 1;
    step(1);
    ready = 1'b0;
    push(24'h2468AC, e + 61);
    push(24'h2468AC, e + 71);
    wait_cyc(e + 50);
    check("fb_not_yet", 32'(fallback), 32'd0);
    step(1);
    check("fb_rise", 32'(fallback), 32'd1);
    wait_cyc(e + 80);
    check("fb_no_ovr_yet", 32'(overrun), 32'd0);
    filter_busy = 1'b1;
    step(1);
    filter_busy = 1'b0;
    check("fb_busy_ovr", 32'(overrun), 32'd1);
    check("fb_still_on", 32'(fallback), 32'd1);
    wait_cyc(e + 85);
    l_in = 24'h13579B;
    ready = 1'b1;
    push(24'h13579B, cyc + 2);
    step(1);
    ready = 1'b0;
    check("fb_cleared", 32'(fallback), 32'd0);
    step(5);

    check("queue_drained", 32'(exp_d.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000 time units want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/codec_sample_bridge.md
CODEC_SAMPLE_BRIDGE -- requirements
Module: codec_sample_bridge

Interface
REQ-001 Parameter W, default 24: audio sample width in bits, two's complement.
REQ-002 Parameter DIV, default 5000: period in clk cycles of the fallback sample strobe.
REQ-003 Parameter TIMEOUT, default 8192: number of clk cycles without a codec ready edge before fallback mode starts.
REQ-004 clk  in  1  system clock; all state is updated on the rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 ready  in  1  codec frame-valid level; a new frame is signalled by its rising edge.
REQ-007 l_bus_out  in  W  left-channel ADC sample from the codec.
REQ-008 r_bus_out  in  W  right-channel ADC sample from the codec.
REQ-009 mode  in  2  source select: 00 left, 01 right, 10 L/R average, 11 mute.
REQ-010 filter_busy  in  1  high while the downstream filter is still processing the previous sample.
REQ-011 clr_ovr  in  1  synchronous clear for the overrun flag.
REQ-012 data_out  out  W  mono sample presented to the filter.
REQ-013 sample_trig  out  1  one-cycle strobe that marks a new data_out.
REQ-014 overrun  out  1  sticky flag: a sample was dropped because the filter was busy.
REQ-015 fallback  out  1  high while the internal DIV strobe replaces the codec timing.

Function
REQ-016 The block SHALL register ready every cycle (ready_q) and SHALL detect an edge when ready=1 and ready_q=0.
REQ-017 The FSM SHALL have states IDLE, CAPTURE and ISSUE; it SHALL reset to IDLE.
- IDLE -> CAPTURE on an edge with filter_busy=0.
- CAPTURE -> ISSUE unconditionally.
- ISSUE -> IDLE unconditionally.
REQ-018 On the edge that enters CAPTURE, the block SHALL latch l_bus_out and r_bus_out into internal registers.
REQ-019 On the CAPTURE->ISSUE edge, the block SHALL update data_out from the latched values. sample_trig SHALL be high for exactly the ISSUE cycle.
REQ-020 Latency SHALL be fixed: sample_trig and data_out become valid 2 rising edges after the edge on which the ready edge was sampled.
REQ-021 data_out SHALL hold its value between strobes.
REQ-022 Mode arithmetic: 00 gives L; 01 gives R; 11 gives 0.
- 10 gives (L+R), computed sign-extended to W+1 bits, then arithmetic-shifted right by 1, rounding toward minus infinity.
- The result is always representable, so no saturation is needed.
REQ-023 mode SHALL be sampled in the CAPTURE cycle; a change at any other time SHALL NOT affect the sample in flight.
REQ-024 A ready edge arriving with filter_busy=1 in IDLE SHALL be dropped: no capture, and overrun is set the next cycle.
REQ-025 A ready edge arriving in CAPTURE or ISSUE SHALL be dropped and SHALL set overrun.
REQ-026 overrun SHALL stay high until clr_ovr=1. If a set condition and clr_ovr occur in the same cycle, set wins.
REQ-027 A 16-bit-or-wider idle counter SHALL reset to 0 on every ready edge and otherwise increment, saturating at TIMEOUT.
- When the counter reaches TIMEOUT, fallback SHALL go high on the next edge.
REQ-028 In fallback, a DIV counter SHALL issue a sample_trig pulse every DIV cycles, with data_out unchanged (last value held).
- The first pulse occurs DIV cycles after fallback rises.
- filter_busy=1 at a fallback tick SHALL suppress that pulse and set overrun.
REQ-029 A ready edge in fallback SHALL do two things in the same cycle: clear fallback and the DIV counter, and be processed as a normal edge per REQ-017.
REQ-030 sample_trig SHALL never be high for two consecutive cycles.

Reset
REQ-031 While reset_n=0, all of the following SHALL apply immediately and regardless of clk: data_out=0, sample_trig=0, overrun=0, fallback=0, FSM=IDLE, all counters=0, ready_q=0, latched L/R=0.
REQ-032 Reset asserted mid-capture SHALL abort the sample; no sample_trig SHALL follow deassertion.
REQ-033 ready already high at deassertion SHALL count as an edge on the first clock after deassertion.

Verification
REQ-034 Left mode: mode=00, L=24'h123456, R=24'h654321, ready rises at edge E0 -> sample_trig high for one cycle after E2, data_out=24'h123456.
REQ-035 Average: mode=10, L=24'h7FFFFF, R=24'h000001 -> data_out=24'h400000. Then L=24'hFFFFFF, R=24'hFFFFFE -> data_out=24'hFFFFFE.
REQ-036 Overrun: filter_busy=1 during a ready edge -> no sample_trig, overrun=1. Hold overrun while clr_ovr=0. Pulse clr_ovr -> overrun=0. Set and clr in the same cycle -> overrun=1.
REQ-037 Fallback: DIV=10, TIMEOUT=50, no ready edges -> fallback=1 after 51 cycles, then sample_trig every 10 cycles with data_out held. A ready edge -> fallback=0 and a normal sample 2 edges later.
REQ-038 Reset abort: reset_n low in the CAPTURE cycle -> outputs 0 asynchronously. After release with ready low, no sample_trig.
REQ-039 Back-to-back: ready edges 2 cycles apart -> the second edge is dropped, overrun=1, and only one sample_trig is seen.
